reg_file_arbiter: RTL and testbench
===================================

Name: reg_file_arbiter

Overview:
Arbitrates the single-port 32x32 register file (one access per clock, registered 1-cycle read) between one writeback requester and two read requesters (operand A and operand B). Sits between decode/writeback and the register file. Sequences accesses, returns read data with fixed latency, and bounds read starvation under continuous writeback.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
STARVE_MAX, 4, consecutive writeback grants tolerated while a read is pending before a read is forced

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wb_valid  in  1  write request
wb_ready  out  1  write accepted this cycle
wb_addr  in  ADDR_W  write address
wb_data  in  DATA_W  write data
rda_valid  in  1  read request, port A
rda_ready  out  1  port A read accepted this cycle
rda_addr  in  ADDR_W  port A address
rda_rsp_valid  out  1  port A read data valid
rda_rsp_data  out  DATA_W  port A read data
rdb_valid/rdb_ready/rdb_addr/rdb_rsp_valid/rdb_rsp_data  same as port A, for port B
rf_reg_write  out  1  to register file: 1 write, 0 read
rf_reg_adress  out  ADDR_W  to register file address
rf_data_write  out  DATA_W  to register file write data
rf_data_read  in  DATA_W  from register file, valid the cycle after a read access

Behaviour:
- Single clock clk; rst synchronous, active-high. While rst=1: all *_ready=0, rf_reg_write=0, rf_reg_adress=0, rf_data_write=0, *_rsp_valid=0; starve_cnt=0, rr_ptr=0 (favour A), rsp_owner=NONE.
- Transfer occurs when valid&ready in the same cycle. ready is combinational from valid and state; requesters must not make valid depend on ready.
- At most one grant per cycle. Priority: wb over reads, unless starve_cnt==STARVE_MAX and a read is valid, then the read wins.
- Between reads: round-robin. rr_ptr=0 favours A, 1 favours B. After any read grant, rr_ptr points to the other port.
- starve_cnt: increments when wb is granted while any read is valid. Clears when a read is granted or no read is valid. Saturates at STARVE_MAX.
- Grant drive: wb gives rf_reg_write=1, addr=wb_addr, data=wb_data. A read gives rf_reg_write=0, addr=rdx_addr. No grant gives rf_reg_write=0, addr=0, data=0 (harmless read).
- Read latency 1: a grant in cycle N gives rdx_rsp_valid=1 for exactly cycle N+1, with rdx_rsp_data=rf_data_read. Otherwise rsp_data=0. rsp_owner register records N's read owner.
- RAW: a write granted in N followed by a read of the same address granted in N+1 or later returns the new data. No bypass needed.
- rst asserted in N+1 after a read grant in N: response suppressed, rsp_owner cleared.

Optional Feature:
REGFILE_G0_ZERO_EN — SPARC %g0 semantics.
- With the macro: a write to address 0 is acknowledged (wb_ready=1) but consumes no port slot. rf_reg_write stays 0, and a read may be granted in the same cycle under normal read arbitration. That cycle does not count as a wb grant for starve_cnt. Reads of address 0 are granted normally, but rsp_data is forced to 0.
- Without the macro: address 0 is an ordinary register.

Decomposition:
- Package reg_file_ctrl_pkg: ADDR_W/DATA_W defaults, G0_ADDR=0, enum gnt_owner_t {GNT_NONE, GNT_WB, GNT_A, GNT_B}.
- Sub-module rd_rr_arb: 2-way round-robin picker with rr_ptr state. Inputs: valid_a, valid_b, advance. Outputs: pick_a, pick_b.

Test Plan:
- Reset: rst=1 for 2 cycles with all valids high -> all ready=0, rf_reg_write=0, rsp_valid=0; first cycle after release grants wb.
- Write wb_addr=5 data=0xDEADBEEF in cycle 0, rda_addr=5 in cycle 1 -> rda_rsp_valid=1 in cycle 2 with 0xDEADBEEF.
- rda (addr 1) and rdb (addr 2) both valid in cycle 0 -> A granted cycle 0, B cycle 1, rsp in cycles 1 and 2. Repeat simultaneous -> B granted first.
- wb_valid and rda_valid held high, STARVE_MAX=4 -> wb granted cycles 0-3, rda granted cycle 4, wb resumes cycle 5.
- G0: wb addr 0 data 0x1234 with rda addr 0 in the same cycle. With REGFILE_G0_ZERO_EN -> both ready same cycle, rsp_data=0. Without -> wb first, then the read returns 0x1234.
- Read granted cycle 0, rst=1 in cycle 1 -> rda_rsp_valid stays 0; no response after rst release.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and defaults for the register-file access arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package reg_file_ctrl_pkg;

    localparam int RF_ADDR_W     = 5;
    localparam int RF_DATA_W     = 32;
    localparam int RF_STARVE_MAX = 4;

    // Architectural zero register (%g0) address.
    localparam int G0_ADDR = 0;

    // Which requester owns the register-file port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_A    = 2'd2,
        GNT_B    = 2'd3
    } gnt_owner_t;

endpackage

// File: rtl/rd_rr_arb.sv
// Two-way round-robin picker between the operand A and operand B read ports.
// Latency: pick is combinational; the pointer updates on the clock after an advance.
// Backpressure: advance is asserted only when the picked read actually owns the port.
module rd_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic valid_a,
    input  logic valid_b,
    input  logic advance,
    output logic pick_a,
    output logic pick_b
);

    // rr_ptr 0 favours A, 1 favours B.
    logic rr_ptr_q;
    logic rr_ptr_d;

    // Pick the favoured port when both request, otherwise whichever requests.
    always_comb begin
        pick_a = valid_a && (!valid_b || !rr_ptr_q);
        pick_b = valid_b && !pick_a;
    end

    // After a read grant the pointer favours the port that was not served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = pick_a;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one single-port register file between writeback and two read ports; optional %g0 via REGFILE_G0_ZERO_EN.
// Latency: grants are same-cycle (ready is combinational); read data returns exactly one cycle after grant.
// Backpressure: writeback wins unless a read has waited STARVE_MAX writeback grants; losers see ready=0 and hold.
module reg_file_arbiter
    import reg_file_ctrl_pkg::*;
#(
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int DATA_W     = RF_DATA_W,
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rda_valid,
    output logic              rda_ready,
    input  logic [ADDR_W-1:0] rda_addr,
    output logic              rda_rsp_valid,
    output logic [DATA_W-1:0] rda_rsp_data,
    input  logic              rdb_valid,
    output logic              rdb_ready,
    input  logic [ADDR_W-1:0] rdb_addr,
    output logic              rdb_rsp_valid,
    output logic [DATA_W-1:0] rdb_rsp_data,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_reg_adress,
    output logic [DATA_W-1:0] rf_data_write,
    input  logic [DATA_W-1:0] rf_data_read
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    gnt_owner_t    rsp_owner_q;
    gnt_owner_t    rsp_owner_d;
    logic          rsp_zero_q;
    logic          rsp_zero_d;

    gnt_owner_t    gnt;
    logic          wb_g0;
    logic          any_rd;
    logic          force_rd;
    logic          rd_gnt;
    logic          pick_a;
    logic          pick_b;

`ifdef REGFILE_G0_ZERO_EN
    // Writes to %g0 are acknowledged without occupying the register-file port.
    assign wb_g0 = wb_valid && (wb_addr == ADDR_W'(G0_ADDR));
`else
    assign wb_g0 = 1'b0;
`endif

    rd_rr_arb u_rd_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_a (rda_valid),
        .valid_b (rdb_valid),
        .advance (rd_gnt),
        .pick_a  (pick_a),
        .pick_b  (pick_b)
    );

    // Decide the single owner of the port this cycle.
    always_comb begin
        any_rd   = rda_valid || rdb_valid;
        force_rd = (starve_q == STARVE_LIM) && any_rd;
        gnt      = GNT_NONE;
        if (!rst) begin
            if (wb_valid && !wb_g0 && !force_rd) begin
                gnt = GNT_WB;
            end else if (pick_a) begin
                gnt = GNT_A;
            end else if (pick_b) begin
                gnt = GNT_B;
            end
        end
        rd_gnt = (gnt == GNT_A) || (gnt == GNT_B);
    end

    // Handshakes and register-file drive; an idle cycle issues a harmless read of address 0.
    always_comb begin
        wb_ready      = (gnt == GNT_WB) || (wb_g0 && !rst);
        rda_ready     = (gnt == GNT_A);
        rdb_ready     = (gnt == GNT_B);
        rf_reg_write  = 1'b0;
        rf_reg_adress = '0;
        rf_data_write = '0;
        case (gnt)
            GNT_WB: begin
                rf_reg_write  = 1'b1;
                rf_reg_adress = wb_addr;
                rf_data_write = wb_data;
            end
            GNT_A:   rf_reg_adress = rda_addr;
            GNT_B:   rf_reg_adress = rdb_addr;
            default: ;
        endcase
    end

    // Starvation count, response owner and %g0 read marker for the next cycle.
    always_comb begin
        starve_d = '0;
        if ((gnt == GNT_WB) && any_rd) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end
        rsp_owner_d = rd_gnt ? gnt : GNT_NONE;
`ifdef REGFILE_G0_ZERO_EN
        rsp_zero_d = ((gnt == GNT_A) && (rda_addr == ADDR_W'(G0_ADDR))) ||
                     ((gnt == GNT_B) && (rdb_addr == ADDR_W'(G0_ADDR)));
`else
        rsp_zero_d = 1'b0;
`endif
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            rsp_owner_q <= GNT_NONE;
            rsp_zero_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // Route last cycle's read data to its owner; reset in the response cycle drops it.
    always_comb begin
        rda_rsp_valid = !rst && (rsp_owner_q == GNT_A);
        rdb_rsp_valid = !rst && (rsp_owner_q == GNT_B);
        rda_rsp_data  = (rda_rsp_valid && !rsp_zero_q) ? rf_data_read : '0;
        rdb_rsp_data  = (rdb_rsp_valid && !rsp_zero_q) ? rf_data_read : '0;
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter with a behavioural register file and reference model.
// Latency: checks ready/drive in the grant cycle and responses one cycle later.
// Backpressure: requesters hold valid until they see ready.
module tb_reg_file_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int SMAX = 4;
`ifdef REGFILE_G0_ZERO_EN
    localparam bit G0EN = 1'b1;
`else
    localparam bit G0EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rda_valid, rda_ready, rda_rsp_valid;
    logic [AW-1:0] rda_addr;
    logic [DW-1:0] rda_rsp_data;
    logic          rdb_valid, rdb_ready, rdb_rsp_valid;
    logic [AW-1:0] rdb_addr;
    logic [DW-1:0] rdb_rsp_data;
    logic          rf_reg_write;
    logic [AW-1:0] rf_reg_adress;
    logic [DW-1:0] rf_data_write;
    logic [DW-1:0] rf_data_read;

    always #5 clk = ~clk;

    reg_file_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .rda_valid     (rda_valid),
        .rda_ready     (rda_ready),
        .rda_addr      (rda_addr),
        .rda_rsp_valid (rda_rsp_valid),
        .rda_rsp_data  (rda_rsp_data),
        .rdb_valid     (rdb_valid),
        .rdb_ready     (rdb_ready),
        .rdb_addr      (rdb_addr),
        .rdb_rsp_valid (rdb_rsp_valid),
        .rdb_rsp_data  (rdb_rsp_data),
        .rf_reg_write  (rf_reg_write),
        .rf_reg_adress (rf_reg_adress),
        .rf_data_write (rf_data_write),
        .rf_data_read  (rf_data_read)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'(i) * 32'h0001_0203 + 32'h5A5A_0000;
    endfunction

    // Behavioural single-port register file with registered read.
    logic [DW-1:0] rf_mem [32];
    logic          tb_init;
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_reg_write) begin
            rf_mem[rf_reg_adress] <= rf_data_write;
        end
        rf_data_read <= rf_mem[rf_reg_adress];
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int            m_starve;
    int            m_rr;
    bit            m_pa, m_pb;
    logic [DW-1:0] m_pa_d, m_pb_d;
    logic [DW-1:0] shadow [32];

    // DUT outputs captured mid-cycle by step().
    logic          cap_wb_rdy, cap_a_rdy, cap_b_rdy;
    logic          cap_a_rsp_v, cap_b_rsp_v;
    logic [DW-1:0] cap_a_rsp_d, cap_b_rsp_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic step();
        int            win;
        bit            g0w;
        bit            any_rd;
        logic [31:0]   e_adr;
        logic [31:0]   e_dat;
        bit            e_pa, e_pb;
        @(negedge clk);
        cap_wb_rdy  = wb_ready;
        cap_a_rdy   = rda_ready;
        cap_b_rdy   = rdb_ready;
        cap_a_rsp_v = rda_rsp_valid;
        cap_b_rsp_v = rdb_rsp_valid;
        cap_a_rsp_d = rda_rsp_data;
        cap_b_rsp_d = rdb_rsp_data;
        win    = 0;
        g0w    = 1'b0;
        any_rd = rda_valid || rdb_valid;
        if (!rst) begin
            g0w = G0EN && wb_valid && (wb_addr == 0);
            if (wb_valid && !g0w && !(m_starve == SMAX && any_rd)) win = 1;
            else if (rda_valid && (!rdb_valid || m_rr == 0)) win = 2;
            else if (rdb_valid) win = 3;
        end
        e_adr = (win == 1) ? 32'(wb_addr) : (win == 2) ? 32'(rda_addr) :
                (win == 3) ? 32'(rdb_addr) : 32'd0;
        e_dat = (win == 1) ? wb_data : 32'd0;
        e_pa  = m_pa && !rst;
        e_pb  = m_pb && !rst;
        chk("wb_ready",      32'(wb_ready),      32'(win == 1 || g0w));
        chk("rda_ready",     32'(rda_ready),     32'(win == 2));
        chk("rdb_ready",     32'(rdb_ready),     32'(win == 3));
        chk("rf_reg_write",  32'(rf_reg_write),  32'(win == 1));
        chk("rf_reg_adress", 32'(rf_reg_adress), e_adr);
        chk("rf_data_write", rf_data_write,      e_dat);
        chk("rda_rsp_valid", 32'(rda_rsp_valid), 32'(e_pa));
        chk("rdb_rsp_valid", 32'(rdb_rsp_valid), 32'(e_pb));
        chk("rda_rsp_data",  rda_rsp_data,       e_pa ? m_pa_d : 32'd0);
        chk("rdb_rsp_data",  rdb_rsp_data,       e_pb ? m_pb_d : 32'd0);
        if (rst) begin
            m_starve = 0;
            m_rr     = 0;
            m_pa     = 1'b0;
            m_pb     = 1'b0;
        end else begin
            m_pa   = (win == 2);
            m_pb   = (win == 3);
            m_pa_d = (G0EN && rda_addr == 0) ? 32'd0 : shadow[rda_addr];
            m_pb_d = (G0EN && rdb_addr == 0) ? 32'd0 : shadow[rdb_addr];
            if (win == 1) shadow[wb_addr] = wb_data;
            m_starve = (win == 1 && any_rd) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            if (win == 2) m_rr = 1;
            else if (win == 3) m_rr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wb_valid = 1'b0; rda_valid = 1'b0; rdb_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        m_starve = 0; m_rr = 0; m_pa = 1'b0; m_pb = 1'b0;
        m_pa_d = '0; m_pb_d = '0;
        tb_init = 1'b1;
        rst = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0BAD_F00D;
        rda_valid = 1'b1; rda_addr = 5'd10;
        rdb_valid = 1'b1; rdb_addr = 5'd11;

        // Reset with every requester asserting.
        step();
        chk("rst_wb_ready", 32'(cap_wb_rdy), 32'd0);
        step();
        chk("rst_rda_ready", 32'(cap_a_rdy), 32'd0);
        tb_init = 1'b0;
        rst = 1'b0;
        step();
        chk("rel_wb_gnt", 32'(cap_wb_rdy), 32'd1);
        chk("rel_rda_wait", 32'(cap_a_rdy), 32'd0);

        // Write then read the same address.
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        wb_valid = 1'b0; rda_valid = 1'b1; rda_addr = 5'd5;
        step();
        rda_valid = 1'b0;
        step();
        chk("raw_rsp_valid", 32'(cap_a_rsp_v), 32'd1);
        chk("raw_rsp_data", cap_a_rsp_d, 32'hDEAD_BEEF);

        // Simultaneous reads: A first, then a repeat with both valid goes to B.
        do_reset();
        rda_valid = 1'b1; rda_addr = 5'd1; rdb_valid = 1'b1; rdb_addr = 5'd2;
        step();
        chk("rr_a_first", 32'(cap_a_rdy), 32'd1);
        rda_addr = 5'd3;
        step();
        chk("rr_b_second", 32'(cap_b_rdy), 32'd1);
        chk("rr_a_rsp", cap_a_rsp_d, init_val(1));
        rdb_valid = 1'b0;
        step();
        chk("rr_a_third", 32'(cap_a_rdy), 32'd1);
        chk("rr_b_rsp", cap_b_rsp_d, init_val(2));
        rda_valid = 1'b0;
        step();
        chk("rr_a_rsp2", cap_a_rsp_d, init_val(3));

        // Continuous writeback against a pending read.
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111_2222;
        rda_valid = 1'b1; rda_addr = 5'd9;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rda_valid = 1'b0;
            step();
            chk($sformatf("starve_wb_c%0d", c), 32'(cap_wb_rdy), 32'(c != 4));
            chk($sformatf("starve_rd_c%0d", c), 32'(cap_a_rdy), 32'(c == 4));
        end
        wb_valid = 1'b0;

        // Write and read of address 0 in the same cycle.
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
        rda_valid = 1'b1; rda_addr = 5'd0;
        step();
`ifdef REGFILE_G0_ZERO_EN
        chk("g0_wb_ready", 32'(cap_wb_rdy), 32'd1);
        chk("g0_rd_ready", 32'(cap_a_rdy), 32'd1);
        wb_valid = 1'b0; rda_valid = 1'b0;
        step();
        chk("g0_rsp_valid", 32'(cap_a_rsp_v), 32'd1);
        chk("g0_rsp_data", cap_a_rsp_d, 32'd0);
`else
        chk("r0_wb_ready", 32'(cap_wb_rdy), 32'd1);
        chk("r0_rd_wait", 32'(cap_a_rdy), 32'd0);
        wb_valid = 1'b0;
        step();
        chk("r0_rd_ready", 32'(cap_a_rdy), 32'd1);
        rda_valid = 1'b0;
        step();
        chk("r0_rsp_data", cap_a_rsp_d, 32'h0000_1234);
`endif

        // Reset in the response cycle drops the response.
        do_reset();
        rda_valid = 1'b1; rda_addr = 5'd7;
        step();
        chk("rstrsp_gnt", 32'(cap_a_rdy), 32'd1);
        rda_valid = 1'b0; rst = 1'b1;
        step();
        chk("rstrsp_drop", 32'(cap_a_rsp_v), 32'd0);
        rst = 1'b0;
        step();
        chk("rstrsp_none", 32'(cap_a_rsp_v), 32'd0);

        // Randomised traffic with held requests.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!wb_valid && $urandom_range(0, 99) < 60) begin
                wb_valid = 1'b1;
                wb_addr  = 5'($urandom_range(0, 31));
                wb_data  = $urandom;
            end
            if (!rda_valid && $urandom_range(0, 99) < 45) begin
                rda_valid = 1'b1;
                rda_addr  = 5'($urandom_range(0, 31));
            end
            if (!rdb_valid && $urandom_range(0, 99) < 45) begin
                rdb_valid = 1'b1;
                rdb_addr  = 5'($urandom_range(0, 31));
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
            if (cap_wb_rdy) wb_valid = 1'b0;
            if (cap_a_rdy)  rda_valid = 1'b0;
            if (cap_b_rdy)  rdb_valid = 1'b0;
        end
        rst = 1'b0; wb_valid = 1'b0; rda_valid = 1'b0; rdb_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
